// File: rtl/falafel_pkg.sv
// Shared types for the falafel request path: opcodes, response status codes
// and the dispatcher state encoding.
package falafel_pkg;

    localparam int OP_W     = 2;
    localparam int STATUS_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_NOP     = 2'b00,
        OP_ALLOC   = 2'b01,
        OP_FREE    = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    // Code 2'b11 is reserved and never produced by the dispatcher.
    typedef enum logic [STATUS_W-1:0] {
        ST_OK      = 2'b00,
        ST_ILLEGAL = 2'b01,
        ST_TIMEOUT = 2'b10
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RSP,
        S_RESP
    } dispatch_state_e;

endpackage

// File: rtl/falafel_req_dispatcher.sv
// Pops falafel requests from a show-ahead FIFO, forwards ALLOC/FREE to the
// allocator core and pushes one status+data word per non-NOP request.
module falafel_req_dispatcher
    import falafel_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                fifo_empty_i,
    input  logic [DATA_W-1:0]   fifo_rdata_i,
    output logic                fifo_read_o,
    output logic                core_req_valid_o,
    input  logic                core_req_ready_i,
    output logic [1:0]          core_req_op_o,
    output logic [DATA_W-3:0]   core_req_payload_o,
    input  logic                core_rsp_valid_i,
    input  logic [DATA_W-3:0]   core_rsp_data_i,
    input  logic                rsp_full_i,
    output logic                rsp_write_o,
    output logic [DATA_W-1:0]   rsp_wdata_o,
    output logic                busy_o,
    output logic [CNT_W-1:0]    illegal_cnt_o
);

    localparam int PAY_W = DATA_W - OP_W;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    dispatch_state_e   state_q, state_d;
    op_e               op_q, op_d;
    logic [PAY_W-1:0]  payload_q, payload_d;
    status_e           status_q, status_d;
    logic [PAY_W-1:0]  data_q, data_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]  illegal_cnt_q, illegal_cnt_d;
    logic              pop;
    logic              push;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        payload_d     = payload_q;
        status_d      = status_q;
        data_d        = data_q;
        tmo_cnt_d     = tmo_cnt_q;
        illegal_cnt_d = illegal_cnt_q;
        pop           = 1'b0;
        push          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty_i) begin
                    pop       = 1'b1;
                    op_d      = op_e'(fifo_rdata_i[DATA_W-1 -: OP_W]);
                    payload_d = fifo_rdata_i[PAY_W-1:0];
                    case (op_d)
                        OP_ALLOC, OP_FREE: state_d = S_ISSUE;
                        OP_ILLEGAL: begin
                            if (illegal_cnt_q != {CNT_W{1'b1}}) begin
                                illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
                            end
                            status_d = ST_ILLEGAL;
                            data_d   = fifo_rdata_i[PAY_W-1:0];
                            state_d  = S_RESP;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_ISSUE: begin
                if (core_req_ready_i) begin
                    tmo_cnt_d = '0;
                    state_d   = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                // A response landing in the final timeout cycle still counts as OK.
                if (core_rsp_valid_i) begin
                    status_d = ST_OK;
                    data_d   = core_rsp_data_i;
                    state_d  = S_RESP;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    status_d = ST_TIMEOUT;
                    data_d   = payload_q;
                    state_d  = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_RESP: begin
                if (!rsp_full_i) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            op_q          <= OP_NOP;
            payload_q     <= '0;
            status_q      <= ST_OK;
            data_q        <= '0;
            tmo_cnt_q     <= '0;
            illegal_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            payload_q     <= payload_d;
            status_q      <= status_d;
            data_q        <= data_d;
            tmo_cnt_q     <= tmo_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    // The pop is combinational from the FIFO flag, so it is masked by reset
    // to keep every output low while reset is held.
    assign fifo_read_o        = pop & ~rst_i;
    assign rsp_write_o        = push;
    assign core_req_valid_o   = (state_q == S_ISSUE);
    assign core_req_op_o      = op_q;
    assign core_req_payload_o = payload_q;
    assign rsp_wdata_o        = {status_q, data_q};
    assign busy_o             = (state_q != S_IDLE);
    assign illegal_cnt_o      = illegal_cnt_q;

endmodule

// File: tb/tb_falafel_req_dispatcher.sv
// Directed bench for falafel_req_dispatcher with queue-based request and
// response FIFOs and a simple allocator core that answers one cycle after accept.
module tb_falafel_req_dispatcher;

    localparam int DATA_W         = 16;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int CNT_W          = 2;
    localparam int PAY_W          = DATA_W - 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              fifoEmpty = 1'b1;
    logic [DATA_W-1:0] fifoRdata = '0;
    logic              fifo_read_o;
    logic              core_req_valid_o;
    logic              coreReady;
    logic [1:0]        core_req_op_o;
    logic [PAY_W-1:0]  core_req_payload_o;
    logic              coreRspModel = 1'b0;
    logic              coreRspManual;
    logic              coreRspValid;
    logic [PAY_W-1:0]  coreRspData;
    logic              rspFull;
    logic              rsp_write_o;
    logic [DATA_W-1:0] rsp_wdata_o;
    logic              busy_o;
    logic [CNT_W-1:0]  illegal_cnt_o;

    logic              coreAuto;
    logic [DATA_W-1:0] reqQ[$];
    logic [DATA_W-1:0] rspQ[$];
    int                popLog[$];
    int                writeLog[$];
    int                acceptLog[$];
    int                validLog[$];
    int                cycleCnt = 0;
    int                errors = 0;
    int                checks = 0;
    bit                stable;

    always #5 clk = ~clk;

    assign coreRspValid = coreRspModel | coreRspManual;

    falafel_req_dispatcher #(
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .fifo_empty_i(fifoEmpty),
        .fifo_rdata_i(fifoRdata),
        .fifo_read_o(fifo_read_o),
        .core_req_valid_o(core_req_valid_o),
        .core_req_ready_i(coreReady),
        .core_req_op_o(core_req_op_o),
        .core_req_payload_o(core_req_payload_o),
        .core_rsp_valid_i(coreRspValid),
        .core_rsp_data_i(coreRspData),
        .rsp_full_i(rspFull),
        .rsp_write_o(rsp_write_o),
        .rsp_wdata_o(rsp_wdata_o),
        .busy_o(busy_o),
        .illegal_cnt_o(illegal_cnt_o)
    );

    // Show-ahead request FIFO, response FIFO capture, core model and event logs.
    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
        if (fifo_read_o && reqQ.size() != 0) begin
            void'(reqQ.pop_front());
            popLog.push_back(cycleCnt);
        end
        fifoEmpty <= (reqQ.size() == 0);
        fifoRdata <= (reqQ.size() != 0) ? reqQ[0] : '0;
        if (rsp_write_o) begin
            rspQ.push_back(rsp_wdata_o);
            writeLog.push_back(cycleCnt);
        end
        if (core_req_valid_o) validLog.push_back(cycleCnt);
        if (core_req_valid_o && coreReady) acceptLog.push_back(cycleCnt);
        coreRspModel <= coreAuto && core_req_valid_o && coreReady;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] word);
        reqQ.push_back(word);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic clearLogs();
        rspQ.delete();
        popLog.delete();
        writeLog.delete();
        acceptLog.delete();
        validLog.delete();
    endtask

    function automatic int logAt(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    function automatic logic [DATA_W-1:0] rspAt(input int idx);
        return (idx < rspQ.size()) ? rspQ[idx] : 16'hDEAD;
    endfunction

    task automatic waitRsp(input string tag, input int n, input int budget);
        int i = 0;
        while (rspQ.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        checkOutput(tag, 32'(rspQ.size() >= n), 32'd1);
    endtask

    task automatic waitCoreValid(input string tag, input int budget);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!core_req_valid_o && i < budget);
        checkOutput(tag, 32'(core_req_valid_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        coreReady     = 1'b0;
        coreAuto      = 1'b0;
        coreRspManual = 1'b0;
        coreRspData   = '0;
        rspFull       = 1'b0;
        tick(2);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_wdata", 32'(rsp_wdata_o), 32'd0);
        checkOutput("rst_illegal", 32'(illegal_cnt_o), 32'd0);
        checkOutput("rst_valid", 32'(core_req_valid_o), 32'd0);
        rst = 1'b0;
        tick(2);

        $display("[TB] ALLOC with immediate core response");
        coreReady   = 1'b1;
        coreAuto    = 1'b1;
        coreRspData = 14'h0A0;
        clearLogs();
        applyStimulus(16'h4010);
        waitRsp("t1_wait", 1, 20);
        tick(1);
        checkOutput("t1_rsp", 32'(rspAt(0)), 32'h00A0);
        checkOutput("t1_latency", 32'(logAt(writeLog, 0) - logAt(popLog, 0)), 32'd3);
        checkOutput("t1_idle", 32'(busy_o), 32'd0);

        $display("[TB] NOP, NOP, FREE");
        coreRspData = 14'h123;
        clearLogs();
        applyStimulus(16'h0055);
        applyStimulus(16'h0011);
        applyStimulus(16'h80A0);
        waitRsp("t2_wait", 1, 20);
        tick(4);
        checkOutput("t2_rsp_count", 32'(rspQ.size()), 32'd1);
        checkOutput("t2_rsp", 32'(rspAt(0)), 32'h0123);
        checkOutput("t2_pops", 32'(popLog.size()), 32'd3);
        checkOutput("t2_nop_gap0", 32'(logAt(popLog, 1) - logAt(popLog, 0)), 32'd1);
        checkOutput("t2_nop_gap1", 32'(logAt(popLog, 2) - logAt(popLog, 1)), 32'd1);
        checkOutput("t2_illegal", 32'(illegal_cnt_o), 32'd0);

        $display("[TB] illegal opcodes and counter saturation");
        clearLogs();
        applyStimulus(16'hC001);
        applyStimulus(16'hC002);
        applyStimulus(16'hC3FF);
        waitRsp("t3_wait", 3, 30);
        tick(2);
        checkOutput("t3_rsp0", 32'(rspAt(0)), 32'h4001);
        checkOutput("t3_rsp1", 32'(rspAt(1)), 32'h4002);
        checkOutput("t3_rsp2", 32'(rspAt(2)), 32'h43FF);
        checkOutput("t3_count", 32'(illegal_cnt_o), 32'd3);
        checkOutput("t3_no_core_req", 32'(validLog.size()), 32'd0);
        applyStimulus(16'hC004);
        waitRsp("t3_wait_sat", 4, 20);
        tick(2);
        checkOutput("t3_rsp3", 32'(rspAt(3)), 32'h4004);
        checkOutput("t3_saturate", 32'(illegal_cnt_o), 32'd3);

        $display("[TB] core timeout");
        coreAuto = 1'b0;
        clearLogs();
        applyStimulus(16'h4123);
        waitRsp("t4_wait", 1, 40);
        checkOutput("t4_rsp", 32'(rspAt(0)), 32'h8123);
        checkOutput("t4_timeout_len", 32'(logAt(writeLog, 0) - logAt(acceptLog, 0)), 32'd9);
        coreRspManual = 1'b1;
        tick(1);
        coreRspManual = 1'b0;
        tick(3);
        checkOutput("t4_late_ignored", 32'(rspQ.size()), 32'd1);
        checkOutput("t4_late_idle", 32'(busy_o), 32'd0);

        $display("[TB] response in the final timeout cycle");
        clearLogs();
        applyStimulus(16'h4124);
        waitCoreValid("t4b_issue", 20);
        tick(8);
        coreRspManual = 1'b1;
        tick(1);
        coreRspManual = 1'b0;
        waitRsp("t4b_wait", 1, 10);
        checkOutput("t4b_rsp_wins", 32'(rspAt(0)), 32'h0123);
        checkOutput("t4b_len", 32'(logAt(writeLog, 0) - logAt(acceptLog, 0)), 32'd9);

        $display("[TB] core not ready stall");
        coreReady = 1'b0;
        coreAuto  = 1'b1;
        clearLogs();
        applyStimulus(16'h4055);
        applyStimulus(16'h0000);
        waitCoreValid("t5_issue", 20);
        stable = 1'b1;
        repeat (5) begin
            tick(1);
            if (!(core_req_valid_o && core_req_op_o == 2'b01 &&
                  core_req_payload_o == 14'h055)) stable = 1'b0;
        end
        checkOutput("t5_stable", 32'(stable), 32'd1);
        checkOutput("t5_no_pop", 32'(popLog.size()), 32'd1);
        checkOutput("t5_no_write", 32'(rspQ.size()), 32'd0);
        coreReady = 1'b1;
        waitRsp("t5_wait", 1, 20);
        tick(3);
        checkOutput("t5_rsp", 32'(rspAt(0)), 32'h0123);
        checkOutput("t5_pop_after", 32'(popLog.size()), 32'd2);

        $display("[TB] response FIFO full stall");
        rspFull = 1'b1;
        clearLogs();
        applyStimulus(16'h4077);
        applyStimulus(16'h0000);
        tick(6);
        tick(4);
        checkOutput("t6_no_write", 32'(rspQ.size()), 32'd0);
        checkOutput("t6_no_pop", 32'(popLog.size()), 32'd1);
        checkOutput("t6_busy", 32'(busy_o), 32'd1);
        rspFull = 1'b0;
        tick(1);
        checkOutput("t6_one_write", 32'(rspQ.size()), 32'd1);
        tick(3);
        checkOutput("t6_rsp", 32'(rspAt(0)), 32'h0123);
        checkOutput("t6_write_count", 32'(rspQ.size()), 32'd1);
        checkOutput("t6_pop_after", 32'(popLog.size()), 32'd2);

        $display("[TB] reset during WAIT_RSP");
        coreAuto = 1'b0;
        clearLogs();
        applyStimulus(16'h4099);
        applyStimulus(16'h8044);
        waitCoreValid("t7_issue", 20);
        tick(3);
        rst = 1'b1;
        #1;
        checkOutput("t7_busy", 32'(busy_o), 32'd0);
        checkOutput("t7_valid", 32'(core_req_valid_o), 32'd0);
        checkOutput("t7_read", 32'(fifo_read_o), 32'd0);
        checkOutput("t7_write", 32'(rsp_write_o), 32'd0);
        checkOutput("t7_wdata", 32'(rsp_wdata_o), 32'd0);
        checkOutput("t7_illegal", 32'(illegal_cnt_o), 32'd0);
        checkOutput("t7_op", 32'(core_req_op_o), 32'd0);
        checkOutput("t7_payload", 32'(core_req_payload_o), 32'd0);
        tick(2);
        coreAuto = 1'b1;
        rst      = 1'b0;
        waitRsp("t7_wait", 1, 20);
        tick(3);
        checkOutput("t7_rsp_count", 32'(rspQ.size()), 32'd1);
        checkOutput("t7_rsp", 32'(rspAt(0)), 32'h0123);
        checkOutput("t7_pops", 32'(popLog.size()), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
